// File: rtl/syncfifo.sv
// syncfifo: single-clock parametrised FIFO with occupancy count, programmable
// almost-full / almost-empty thresholds, optional first-word-fall-through
// output and sticky overflow / underflow error flags.
//
// Parameters
//   WIDTH     data width in bits (>= 1)
//   DEPTH     number of entries, power of two, >= 2
//   AF_LEVEL  almost_full  asserts when count >= AF_LEVEL
//   AE_LEVEL  almost_empty asserts when count <= AE_LEVEL
//   FWFT      0 = registered read, 1 = first-word-fall-through
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   write_en      write request
//   read_en       read request
//   err_clr       clears overflow / underflow (an error in the same cycle wins)
//   data_in       write data
//   out           read data (FWFT=1: head word, valid while empty=0)
//   full, empty, almost_full, almost_empty   decoded from the registered count
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
module syncfifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic             read_en,
    input  logic             err_clr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;
    logic             rd_ok;
    logic             wr_ok;

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle.
    assign rd_ok = read_en && !empty;
    assign wr_ok = write_en && (!full || rd_ok);

    always_comb begin
        count_d = count_q;
        if (wr_ok && !rd_ok) begin
            count_d = count_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    // Setting has priority over clearing so no error event is ever lost.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (err_clr) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (write_en && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (read_en && !rd_ok) begin
            underflow_d = 1'b1;
        end
    end

    // Storage is deliberately left out of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; meaningless while empty.
            assign out = mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [WIDTH-1:0] out_q;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    out_q <= '0;
                end else if (rd_ok) begin
                    out_q <= mem_q[rd_ptr_q];
                end
            end
            assign out = out_q;
        end
    endgenerate

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_syncfifo.sv
// Testbench for syncfifo: a registered-read instance and a FWFT instance are
// driven with identical stimulus and compared every cycle against a
// queue-based behavioural model, plus directed literal expectations.
module tb_syncfifo;

    localparam int W = 8;
    localparam int D = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         write_en = 1'b0;
    logic         read_en = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] data_in = '0;

    logic [W-1:0] out0, out1;
    logic         full0, empty0, af0, ae0, ovf0, unf0;
    logic         full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0]   count0, count1;

    int checks = 0;
    int failures = 0;

    syncfifo #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut0 (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .err_clr(err_clr), .data_in(data_in), .out(out0), .full(full0),
        .empty(empty0), .almost_full(af0), .almost_empty(ae0),
        .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    syncfifo #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut1 (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en),
        .err_clr(err_clr), .data_in(data_in), .out(out1), .full(full1),
        .empty(empty1), .almost_full(af1), .almost_empty(ae1),
        .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_q[$];
    logic [W-1:0] m_out0 = '0;
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_out0 = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            bit rd, wr;
            rd = read_en && (m_q.size() > 0);
            wr = write_en && ((m_q.size() < D) || rd);
            if (err_clr) begin
                m_ovf = 1'b0;
                m_unf = 1'b0;
            end
            if (write_en && !wr) m_ovf = 1'b1;
            if (read_en && !rd)  m_unf = 1'b1;
            if (rd) m_out0 = m_q.pop_front();
            if (wr) m_q.push_back(data_in);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        int n;
        n = m_q.size();
        check("count0", 32'(count0), 32'(n));
        check("count1", 32'(count1), 32'(n));
        check("count_le_depth", 32'(count0 <= 5'(D)), 32'd1);
        check("empty0", 32'(empty0), 32'(n == 0));
        check("empty1", 32'(empty1), 32'(n == 0));
        check("full0", 32'(full0), 32'(n == D));
        check("full1", 32'(full1), 32'(n == D));
        check("af0", 32'(af0), 32'(n >= D - 2));
        check("af1", 32'(af1), 32'(n >= D - 2));
        check("ae0", 32'(ae0), 32'(n <= 2));
        check("ae1", 32'(ae1), 32'(n <= 2));
        check("ovf0", 32'(ovf0), 32'(m_ovf));
        check("ovf1", 32'(ovf1), 32'(m_ovf));
        check("unf0", 32'(unf0), 32'(m_unf));
        check("unf1", 32'(unf1), 32'(m_unf));
        check("out0", 32'(out0), 32'(m_out0));
        if (n > 0) check("out1_head", 32'(out1), 32'(m_q[0]));
    end

    // One clock edge of stimulus; returns 2 time units after the edge.
    task automatic step(input logic we, input logic re, input logic [W-1:0] din,
                        input logic clr = 1'b0);
        write_en = we;
        read_en  = re;
        data_in  = din;
        err_clr  = clr;
        @(posedge clk);
        #2;
        write_en = 1'b0;
        read_en  = 1'b0;
        err_clr  = 1'b0;
        $display("txn we=%0d re=%0d clr=%0d din=%02h -> count=%0d out0=%02h out1=%02h ovf=%0d unf=%0d",
                 we, re, clr, din, count0, out0, out1, ovf0, unf0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_count", 32'(count0), 32'd0);
        check("rst_empty", 32'(empty0), 32'd1);
        check("rst_full", 32'(full0), 32'd0);
        check("rst_ae", 32'(ae0), 32'd1);
        check("rst_af", 32'(af0), 32'd0);
        check("rst_out", 32'(out0), 32'd0);
        reset = 1'b1;
        step(1'b0, 1'b0, 8'h00);

        // fill 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            check("fill_count", 32'(count0), 32'(i));
            check("fill_af", 32'(af0), 32'(i >= 14));
        end
        check("fill_full", 32'(full0), 32'd1);

        // rejected 17th write
        step(1'b1, 1'b0, 8'hAA);
        check("ovf_set", 32'(ovf0), 32'd1);
        check("ovf_count", 32'(count0), 32'd16);

        // drain in order
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("drain_out", 32'(out0), 32'(i + 1));
            check("drain_count", 32'(count0), 32'(15 - i));
            check("drain_ae", 32'(ae0), 32'((15 - i) <= 2));
        end
        check("drain_empty", 32'(empty0), 32'd1);

        // read while empty
        step(1'b0, 1'b1, 8'h00);
        check("unf_set", 32'(unf0), 32'd1);
        check("unf_out_hold", 32'(out0), 32'h10);

        // err_clr clears both
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("clr_ovf", 32'(ovf0), 32'd0);
        check("clr_unf", 32'(unf0), 32'd0);

        // simultaneous read+write at empty, FWFT fall-through of 0x5A
        step(1'b1, 1'b1, 8'h5A);
        check("sim_empty_count", 32'(count0), 32'd1);
        check("sim_empty_unf", 32'(unf0), 32'd1);
        check("fwft_empty", 32'(empty1), 32'd0);
        check("fwft_out", 32'(out1), 32'h5A);
        check("sim_empty_out0_hold", 32'(out0), 32'h10);
        step(1'b0, 1'b1, 8'h00);
        check("fwft_pop_empty", 32'(empty1), 32'd1);
        check("reg_read_5a", 32'(out0), 32'h5A);

        // set wins over err_clr
        step(1'b0, 1'b1, 8'h00, 1'b1);
        check("set_wins_unf", 32'(unf0), 32'd1);
        step(1'b0, 0, 8'h00, 1'b1);
        check("clr_unf2", 32'(unf0), 32'd0);

        // refill, then simultaneous read+write at full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h80 + i));
        step(1'b1, 1'b1, 8'hBB);
        check("sim_full_count", 32'(count0), 32'd16);
        check("sim_full_out", 32'(out0), 32'h80);
        check("sim_full_ovf", 32'(ovf0), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check("sim_full_drain", 32'(out0), (i < 15) ? 32'(8'h81 + i) : 32'hBB);
        end

        // wrap-around with random data, checked by the model
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom));
        check("wrap_count", 32'(count0), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

        // mid-operation reset with count=7 and a sticky flag set
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        check("pre_rst_count", 32'(count0), 32'd7);
        check("pre_rst_unf", 32'(unf0), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count0), 32'd0);
        check("mid_rst_empty", 32'(empty0), 32'd1);
        check("mid_rst_out", 32'(out0), 32'd0);
        check("mid_rst_unf", 32'(unf0), 32'd0);
        check("mid_rst_ae", 32'(ae0), 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        step(1'b1, 1'b0, 8'h33);
        check("post_rst_fwft", 32'(out1), 32'h33);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_read", 32'(out0), 32'h33);
        check("post_rst_empty", 32'(empty0), 32'd1);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/syncfifo.md
# syncfifo

Single-clock, parametrised FIFO: the same-clock successor to the dual-clock FIFO. It generalises data width and depth, adds a level count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) output mode, and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain.

## Interface
- WIDTH, 8: data width in bits (≥1).
- DEPTH, 16: number of entries; power of two, ≥2.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL (1..DEPTH).
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1).
- FWFT, 0: 0 = registered-read mode; 1 = first-word-fall-through mode.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_en  input  1  write request.
- read_en  input  1  read request.
- err_clr  input  1  clears overflow/underflow.
- data_in  input  WIDTH  write data.
- out  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- almost_empty  output  1  count ≤ AE_LEVEL.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a write was rejected.
- underflow  output  1  sticky; a read was rejected.

## Operation
- Storage: a DEPTH×WIDTH array with write and read pointers of width $clog2(DEPTH). Pointers wrap naturally from DEPTH-1 to 0. The array itself is not reset.
- Read accept: `rd_ok = read_en && !empty`.
- Write accept: `wr_ok = write_en && (!full || rd_ok)`. A simultaneous read and write when full is accepted, and count stays at DEPTH.
- A simultaneous read and write when empty: the write is accepted, the read is rejected (underflow), and count becomes 1.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- All flags are decoded from the registered count, so they reflect the state after the last edge.
- FWFT=0:
  - out is a register, loaded with mem[rd_ptr] on the edge where rd_ok.
  - out holds its value otherwise, including across a rejected read.
- FWFT=1:
  - out continuously shows mem[rd_ptr], the head word, and is valid while empty=0.
  - rd_ok pops the head, and the next word appears after that edge.
  - While empty=1, out is don't-care; the bench must not check it.
- overflow is set on write_en && !wr_ok. underflow is set on read_en && !rd_ok.
- Both error flags are cleared by err_clr. If an error and err_clr occur in the same cycle, set wins.
- Reset (asynchronous assert, at any time including mid-transfer):
  - Pointers and count go to 0.
  - out = 0, empty = 1, full = 0, almost_empty = 1, almost_full = 0, overflow = 0, underflow = 0.
  - Stored data is discarded.
- Reset deassertion: operation resumes on the first rising clk edge after reset goes high.

## Timing
- Write-to-flag latency: 1 cycle. empty falls the edge after the first wr_ok.
- FWFT=0 read latency: data appears on out 1 cycle after the rd_ok edge. Write-to-readable: the word can be read in the cycle after its write.
- FWFT=1: a word written at edge N is on out after edge N. empty=0 from that same edge, so it can be popped at edge N+1.
- Throughput: one write and one read per cycle, sustained indefinitely.
- Full to not-full: full drops the edge after a lone rd_ok.

## Test plan
- Reset then fill (DEPTH=16, WIDTH=8, FWFT=0):
  - Write 0x01..0x10 over 16 cycles.
  - count steps 1..16; almost_full rises at count=14; full=1 after the 16th write.
  - A 17th write (0xAA) is rejected, overflow=1, count stays 16.
- Drain in order:
  - Read 16 times; out sequence is 0x01..0x10, each one cycle after its rd_ok.
  - almost_empty rises at count=2; empty=1 after the last read.
  - A further read sets underflow=1 and out holds 0x10.
- Simultaneous read and write:
  - At full: count stays 16, both accepted, the oldest word is popped, the new word lands at the tail.
  - At empty: the write is accepted, count=1, underflow=1.
- Wrap-around:
  - Run 40 interleaved write/read pairs with random data.
  - Output order matches input order across pointer wrap, and count never exceeds DEPTH.
- FWFT=1:
  - Write 0x5A into an empty FIFO; after that edge, empty=0 and out=0x5A with no read issued.
  - Read pops it, and empty=1 on the next edge.
- Reset mid-operation:
  - With count=7, pulse reset low between edges.
  - Immediately: count=0, empty=1, out=0, flags cleared.
  - After release, write 0x33 and read it back as 0x33.
  - Check err_clr clears overflow, and that set wins when both occur in the same cycle.
